// File: rtl/fp_mul_normalize_round.sv
// fp_mul_normalize_round
//   Back end of the FP32 multiplier. Normalises the raw 48-bit significand
//   product, rounds it by the RISC-V rm field and packs an IEEE-754 binary32
//   result with overflow / underflow / inexact flags.
//   Two register stages with a valid/ready handshake:
//     stage 1: leading-zero count, left shift, exponent adjust
//     stage 2: round, special-case priority, pack (this is the output register)
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake
//   prod                  unsigned 24x24 significand product
//   exp_in                signed biased exponent sum (ea+eb-127)
//   sign_in               result sign
//   is_nan / is_inf       special-case overrides (is_nan wins)
//   rm                    rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, else RNE)
//   out_valid / out_ready output handshake
//   result                packed binary32
//   flag_of/uf/nx         overflow, underflow (flush-to-zero), inexact
module fp_mul_normalize_round #(
    parameter int EXP_IN_W = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [47:0]         prod,
    input  logic [EXP_IN_W-1:0] exp_in,
    input  logic                sign_in,
    input  logic                is_nan,
    input  logic                is_inf,
    input  logic [2:0]          rm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         result,
    output logic                flag_of,
    output logic                flag_uf,
    output logic                flag_nx
);

    localparam int EW = EXP_IN_W + 1;

    // stage 1 registers
    logic          s1_valid_q, s1_valid_d;
    logic [47:0]   norm_q, norm_d;
    logic [EW-1:0] e1_q, e1_d;
    logic          sign_q, sign_d;
    logic          nan_q, nan_d;
    logic          inf_q, inf_d;
    logic          zero_q, zero_d;
    logic [2:0]    rm_q, rm_d;

    // stage 2 (output) registers
    logic          s2_valid_q, s2_valid_d;
    logic [31:0]   result_q, result_d;
    logic          of_q, of_d;
    logic          uf_q, uf_d;
    logic          nx_q, nx_d;

    // handshake
    logic s2_free;
    logic s1_move;
    logic in_accept;

    // stage 1 combinational
    logic [5:0]    lz;
    logic [47:0]   norm_calc;
    logic [EW-1:0] e1_calc;

    // stage 2 combinational
    logic [22:0]   mant;
    logic          g_bit, s_bit, lsb_bit;
    logic          inc, away;
    logic [23:0]   mant_sum;
    logic [EW-1:0] e2;
    logic          pre_uf;
    logic [31:0]   res_calc;
    logic          of_calc, uf_calc, nx_calc;

    // The normalised MSB is implied by zero_q; it is carried only to keep
    // the stage register a straight copy of the shifted product.
    logic          unused_norm_msb;
    assign unused_norm_msb = norm_q[47];

    assign s2_free   = ~s2_valid_q | out_ready;
    assign in_ready  = ~s1_valid_q | s2_free;
    assign s1_move   = s1_valid_q & s2_free;
    assign in_accept = in_valid & in_ready;

    // Leading-zero count: highest set bit wins because it is visited last.
    always_comb begin
        lz = 6'd48;
        for (int i = 0; i < 48; i++) begin
            if (prod[i]) begin
                lz = 6'(47 - i);
            end
        end
        norm_calc = prod << lz;
        // two's complement in EW bits: sign-extend exp_in, +1, -lz
        e1_calc   = {exp_in[EXP_IN_W-1], exp_in} + EW'(1) - EW'(lz);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        norm_d     = norm_q;
        e1_d       = e1_q;
        sign_d     = sign_q;
        nan_d      = nan_q;
        inf_d      = inf_q;
        zero_d     = zero_q;
        rm_d       = rm_q;
        if (in_accept) begin
            s1_valid_d = 1'b1;
            norm_d     = norm_calc;
            e1_d       = e1_calc;
            sign_d     = sign_in;
            nan_d      = is_nan;
            inf_d      = is_inf;
            zero_d     = (prod == 48'h0);
            rm_d       = rm;
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        mant    = norm_q[46:24];
        g_bit   = norm_q[23];
        s_bit   = |norm_q[22:0];
        lsb_bit = norm_q[24];

        case (rm_q)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sign_q & (g_bit | s_bit);
            3'b011:  inc = ~sign_q & (g_bit | s_bit);
            3'b100:  inc = g_bit;
            default: inc = g_bit & (s_bit | lsb_bit);
        endcase

        // whether an overflow rounds to infinity or saturates to max finite
        case (rm_q)
            3'b001:  away = 1'b0;
            3'b010:  away = sign_q;
            3'b011:  away = ~sign_q;
            default: away = 1'b1;
        endcase

        // carry out leaves mant_sum[22:0] at zero, exponent bumps by one
        mant_sum = {1'b0, mant} + 24'(inc);
        e2       = e1_q + EW'(mant_sum[23]);
        pre_uf   = e1_q[EW-1] | (e1_q == '0);

        res_calc = {sign_q, e2[7:0], mant_sum[22:0]};
        of_calc  = 1'b0;
        uf_calc  = 1'b0;
        nx_calc  = g_bit | s_bit;

        if (nan_q) begin
            res_calc = 32'h7FC0_0000;
            nx_calc  = 1'b0;
        end else if (inf_q) begin
            res_calc = {sign_q, 8'hFF, 23'h0};
            nx_calc  = 1'b0;
        end else if (zero_q) begin
            res_calc = {sign_q, 31'h0};
            nx_calc  = 1'b0;
        end else if (pre_uf) begin
            res_calc = {sign_q, 31'h0};
            uf_calc  = 1'b1;
            nx_calc  = 1'b1;
        end else if (e2[EW-2:0] >= (EW-1)'(255)) begin
            // e1 >= 1 here, so e2 is non-negative and the magnitude compare holds
            res_calc = away ? {sign_q, 8'hFF, 23'h0} : {sign_q, 8'hFE, 23'h7F_FFFF};
            of_calc  = 1'b1;
            nx_calc  = 1'b1;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        of_d       = of_q;
        uf_d       = uf_q;
        nx_d       = nx_q;
        if (s1_move) begin
            s2_valid_d = 1'b1;
            result_d   = res_calc;
            of_d       = of_calc;
            uf_d       = uf_calc;
            nx_d       = nx_calc;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            norm_q     <= '0;
            e1_q       <= '0;
            sign_q     <= 1'b0;
            nan_q      <= 1'b0;
            inf_q      <= 1'b0;
            zero_q     <= 1'b0;
            rm_q       <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            of_q       <= 1'b0;
            uf_q       <= 1'b0;
            nx_q       <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            norm_q     <= norm_d;
            e1_q       <= e1_d;
            sign_q     <= sign_d;
            nan_q      <= nan_d;
            inf_q      <= inf_d;
            zero_q     <= zero_d;
            rm_q       <= rm_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            of_q       <= of_d;
            uf_q       <= uf_d;
            nx_q       <= nx_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign flag_of   = of_q;
    assign flag_uf   = uf_q;
    assign flag_nx   = nx_q;

endmodule
